// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply unit.
//   mdu_op_t    : multiply flavour decoded by the core (MULTU / MUL)
//   mdu_state_t : multiply-controller FSM states
//   MDU_WIDTH   : default operand width
package mips_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic {
        MULTU = 1'b0,   // unsigned, product goes to HI/LO
        MUL   = 1'b1    // signed, low word goes to rd
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_datapath.sv
// Multiplier datapath: radix-2 shift-add accumulator with sign fix-up.
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : capture operand magnitudes and sign flag
//   step         : perform one shift-add iteration
//   op           : operation being loaded (MULTU / MUL)
//   srca, srcb   : operands
//   product      : accumulator, negated when the sign flag is set
module mdu_datapath
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 op,
    input  logic [WIDTH-1:0]     srca,
    input  logic [WIDTH-1:0]     srcb,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               sign_q;

    logic               is_mul;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;

    assign is_mul = (mdu_op_t'(op) == MUL);

    // The most negative value negates to itself; read as unsigned it is the
    // correct magnitude, so no extra bit is needed.
    assign mag_a = (is_mul && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
    assign mag_b = (is_mul && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;

    // Upper half plus multiplicand keeps its carry, which shifts back in.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
        end else if (load) begin
            mcand_q <= mag_a;
            acc_q   <= {{WIDTH{1'b0}}, mag_b};
            sign_q  <= is_mul & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        end else if (step) begin
            acc_q   <= {sum, acc_q[WIDTH-1:1]};
        end
    end

    assign product = sign_q ? (~acc_q + 1'b1) : acc_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply unit controller: FSM, iteration counter, HI/LO/result registers
// and pipeline stall generation around an iterative shift-add datapath.
//   clk, reset_n       : clock and asynchronous active-low reset
//   start, op          : multiply issue and flavour (0 MULTU, 1 MUL)
//   srca, srcb         : operands
//   flush              : squash any in-flight operation
//   rd_hilo, rd_sel    : mfhi/mflo request and select (0 LO, 1 HI)
//   hilo_out           : selected HI or LO register
//   result, wb_en      : MUL low word and its write-back strobe
//   busy, stall, done  : progress, pipeline freeze, completion pulse
module mdu_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               flush,
    input  logic               rd_hilo,
    input  logic               rd_sel,
    output logic [WIDTH-1:0]   hilo_out,
    output logic [WIDTH-1:0]   result,
    output logic               wb_en,
    output logic               busy,
    output logic               stall,
    output logic               done
);

    localparam int unsigned      CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    mdu_state_t         state_q;
    mdu_op_t            op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   res_q;

    logic               accept;
    logic               step;
    logic [2*WIDTH-1:0] product;

    // A start is only taken when the unit is free; while busy the core stalls
    // and reissues it.
    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start && !flush;
    assign step   = (state_q == CALC);

    mdu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .step    (step),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .product (product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= MULTU;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= CALC;
                        cnt_q   <= '0;
                        op_q    <= mdu_op_t'(op);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (op_q == MUL) begin
                        res_q <= product[WIDTH-1:0];
                    end else begin
                        hi_q <= product[2*WIDTH-1:WIDTH];
                        lo_q <= product[WIDTH-1:0];
                    end
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done     = (state_q == DONE);
    assign wb_en    = done && (op_q == MUL);
    assign busy     = (state_q == CALC) || (state_q == FIX);
    assign stall    = busy && (start || rd_hilo);
    assign hilo_out = rd_sel ? hi_q : lo_q;
    assign result   = res_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width in bits.
REQ-002 SHALL have parameter ITER, default WIDTH, meaning the number of shift-add iterations per operation.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have port start, input, 1 bit: the decoder issues a multiply this cycle.
REQ-006 SHALL have port op, input, 1 bit: 0 = MULTU (unsigned; writes HI/LO), 1 = MUL (signed; writes low word to rd).
REQ-007 SHALL have ports srca and srcb, input, WIDTH bits each: the operands.
REQ-008 SHALL have port flush, input, 1 bit: squash any in-flight operation (exception or undefined instruction).
REQ-009 SHALL have port rd_hilo, input, 1 bit: the core requests an mfhi/mflo read this cycle.
REQ-010 SHALL have port rd_sel, input, 1 bit: 0 = LO, 1 = HI.
REQ-011 SHALL have port hilo_out, output, WIDTH bits: the selected HI or LO value.
REQ-012 SHALL have port result, output, WIDTH bits: the low product word for MUL.
REQ-013 SHALL have port wb_en, output, 1 bit: write result to rd this cycle.
REQ-014 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-015 SHALL have port stall, output, 1 bit: freeze the core PC and pipeline this cycle.
REQ-016 SHALL have port done, output, 1 bit: a one-cycle completion pulse.

Function
REQ-017 SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-018 SHALL, in IDLE or DONE with start=1 and flush=0, latch the operands and go to CALC. For MUL the latched operands are magnitudes, plus a sign flag equal to srca[31]^srcb[31].
REQ-019 SHALL, in CALC, perform one radix-2 shift-add step per cycle on a 2*WIDTH-bit accumulator, advance a counter from 0 to ITER-1, and move to FIX after ITER cycles.
REQ-020 SHALL, in FIX, negate the accumulator (two's complement over 2*WIDTH bits) if the sign flag is set, then update the registers. For MULTU it writes HI and LO. For MUL it writes only the result register and leaves HI and LO unchanged.
REQ-021 SHALL make the latency exactly ITER+2 cycles: start is high in cycle 0 and done is high in cycle ITER+2 (cycle 34 with defaults).
REQ-022 SHALL hold done high only in DONE, and hold wb_en equal to done AND latched op==MUL.
REQ-023 SHALL drive busy high in CALC and FIX only.
REQ-024 SHALL drive stall as busy AND (start OR rd_hilo); a start issued while busy is ignored, and the core reissues it.
REQ-025 SHALL drive hilo_out combinationally from rd_sel and the HI/LO registers; in DONE it returns the new values.
REQ-026 SHALL, on flush=1 in any state, go to IDLE next cycle with no done, no wb_en, HI/LO unchanged; flush overrides a simultaneous start.
REQ-027 SHALL handle the boundary operand 0x80000000 under MUL as magnitude 0x80000000 with no overflow.
REQ-028 SHALL accept a start during DONE as a back-to-back operation; the next done occurs ITER+2 cycles later.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously force: state=IDLE, counter=0, HI=LO=result=0, accumulator=0, sign flag=0.
REQ-030 SHALL hold all outputs at 0 during reset, except hilo_out=0 as well.
REQ-031 SHALL, when reset is asserted mid-CALC, abandon the operation and produce no done after release.

Structure
REQ-032 SHALL place mdu_op_t (MULTU, MUL), mdu_state_t (IDLE, CALC, FIX, DONE) and the default WIDTH in the shared mips_pkg package.
REQ-033 SHALL split the design into two levels: mdu_ctrl holds the FSM, counter, HI/LO registers and stall logic, and one sub-module mdu_datapath holds the accumulator, the shift-add step and the negation.

Verification
REQ-034 SHALL check: MULTU 0xFFFFFFFF*0xFFFFFFFF -> done in cycle 34, HI=0xFFFFFFFE, LO=0x00000001, wb_en=0.
REQ-035 SHALL check: MUL -3*5 -> result=0xFFFFFFF1, wb_en=1 in cycle 34, HI/LO unchanged.
REQ-036 SHALL check: MUL 0x80000000*0x80000000 -> result=0x00000000; MULTU of the same operands -> HI=0x40000000, LO=0.
REQ-037 SHALL check: mfhi (rd_hilo=1, rd_sel=1) in cycle 5 -> stall=1 through cycle 33, stall=0 in cycle 34, hilo_out=new HI.
REQ-038 SHALL check: flush in cycle 10 -> IDLE in cycle 11, no done, HI/LO hold their previous values.
REQ-039 SHALL check: reset_n low in cycle 20 -> outputs 0 immediately; a new start after release completes normally in 34 cycles.
